// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  localparam logic [3:0] PAT_DEFAULT = 4'b1011;

endpackage

// File: rtl/seq_match_core.sv
// Moore-style programmable pattern matcher: history shift register,
// saturating valid-bit count and a registered match flag.
module seq_match_core #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int VC_W = $clog2(PAT_W + 1);
  localparam logic [VC_W-1:0] VC_FULL = VC_W'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [VC_W-1:0]  vcnt_q, vcnt_d;
  logic             match_q, match_d;

  // Shift the new bit into history, count valid bits and compare to the pattern.
  always_comb begin
    hist_d  = hist_q;
    vcnt_d  = vcnt_q;
    match_d = 1'b0;
    if (clr) begin
      hist_d = '0;
      vcnt_d = '0;
    end else if (en) begin
      hist_d = {hist_q[PAT_W-2:0], bit_in};
      if (vcnt_q != VC_FULL) begin
        vcnt_d = vcnt_q + VC_W'(1);
      end
      if ((hist_d == pattern) && (vcnt_d == VC_FULL)) begin
        match_d = 1'b1;
        if (!overlap) begin
          vcnt_d = '0;
        end
      end
    end
  end

  // Matcher state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      vcnt_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      vcnt_q  <= vcnt_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: accepts a word, serialises it MSB-first through the
// pattern matcher, tallies matches and reports completion.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int               WORD_W  = 16,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEFAULT),
  parameter int               CNT_W   = $clog2(WORD_W + 1),
  parameter int               POS_W   = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_overlap,
  output logic              busy,
  output logic              det_x,
  output logic              det_z,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [POS_W-1:0]  first_pos,
  output logic              first_vld
);

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WORD_W - 1);

  scan_state_e       state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              ovl_q, ovl_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [POS_W-1:0]  bit_idx_q, bit_idx_d;
  logic [POS_W-1:0]  last_idx_q, last_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0]  fpos_q, fpos_d;
  logic              fvld_q, fvld_d;
  logic              accept;
  logic              core_en;
  logic              core_match;

  seq_match_core #(
    .PAT_W(PAT_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (core_en),
    .bit_in (shreg_q[WORD_W-1]),
    .pattern(pat_q),
    .overlap(ovl_q),
    .match  (core_match)
  );

  // Next-state, serialiser and result tally; a new accept overrides the tally.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    ovl_d      = ovl_q;
    pat_d      = pat_q;
    bit_idx_d  = bit_idx_q;
    last_idx_d = last_idx_q;
    cnt_d      = cnt_q;
    fpos_d     = fpos_q;
    fvld_d     = fvld_q;
    accept     = 1'b0;
    core_en    = 1'b0;

    if (core_match) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!fvld_q) begin
        fpos_d = last_idx_q;
        fvld_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pat;
        end
        if (in_valid) begin
          accept    = 1'b1;
          shreg_d   = in_data;
          ovl_d     = in_overlap;
          cnt_d     = '0;
          fpos_d    = '0;
          fvld_d    = 1'b0;
          bit_idx_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        core_en    = 1'b1;
        shreg_d    = {shreg_q[WORD_W-2:0], 1'b0};
        last_idx_d = bit_idx_q;
        bit_idx_d  = bit_idx_q + POS_W'(1);
        if (bit_idx_q == LAST_IDX) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      ovl_q      <= 1'b0;
      pat_q      <= PAT_RST;
      bit_idx_q  <= '0;
      last_idx_q <= '0;
      cnt_q      <= '0;
      fpos_q     <= '0;
      fvld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      ovl_q      <= ovl_d;
      pat_q      <= pat_d;
      bit_idx_q  <= bit_idx_d;
      last_idx_q <= last_idx_d;
      cnt_q      <= cnt_d;
      fpos_q     <= fpos_d;
      fvld_q     <= fvld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT) || (state_q == FLUSH);
  assign det_x     = (state_q == SHIFT) ? shreg_q[WORD_W-1] : 1'b0;
  assign det_z     = core_match;
  assign done      = (state_q == DONE);
  assign match_cnt = cnt_q;
  assign first_pos = fpos_q;
  assign first_vld = fvld_q;

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Scan controller for the serial pattern-detector path. It accepts a parallel word over a valid/ready handshake and serialises it MSB-first into an internal Moore-style programmable pattern matcher. It counts matches, records the first match position, and reports completion. The pattern and the overlap mode are configurable between scans.

Parameters:
WORD_W, 16, bits per scanned word
PAT_W, 4, pattern length in bits (2..WORD_W)
PAT_RST, 4'b1011, pattern loaded at reset
CNT_W, $clog2(WORD_W+1), width of match counter (sized so overflow is impossible)
POS_W, $clog2(WORD_W), width of position field

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  pattern write strobe; honoured only in IDLE
cfg_pat  in  PAT_W  new pattern, MSB = first bit
in_valid  in  1  word available
in_ready  out  1  controller can accept a word
in_data  in  WORD_W  word to scan; bit WORD_W-1 is scanned first
in_overlap  in  1  1 = overlapping matches allowed; sampled at accept
busy  out  1  scan in progress (SHIFT or FLUSH)
det_x  out  1  serial bit currently presented to the matcher
det_z  out  1  Moore match output; high one cycle after the last pattern bit
done  out  1  one-cycle completion pulse
match_cnt  out  CNT_W  matches found in the current/last word
first_pos  out  POS_W  bit index (0 = MSB) of the last bit of the first match
first_vld  out  1  first_pos is meaningful

Behaviour:
- Reset (async, immediate). All outputs are 0 except in_ready=1; state=IDLE; pattern=PAT_RST; history and counters are cleared.
- Reset mid-scan discards the word. No done pulse is produced.
- FSM states: IDLE, SHIFT, FLUSH, DONE.
- IDLE:
  - in_ready=1.
  - cfg_we loads cfg_pat.
  - in_valid & in_ready at edge E0 latches in_data and in_overlap; clears match_cnt, first_pos and first_vld; clears history and the valid-bit count; goes to SHIFT.
  - cfg_we and in_valid on the same edge: both take effect, and the new pattern applies to this word.
- SHIFT:
  - Lasts exactly WORD_W cycles. bit k (k = 0..WORD_W-1) is on det_x during the cycle after edge Ek.
  - Each edge shifts the bit into the history register and increments a saturating valid-bit count (saturates at PAT_W).
  - Match condition: updated history == pattern and valid count reaches PAT_W. It registers det_z=1 for the cycle after the edge that consumed the final bit.
  - On a match: match_cnt increments. If first_vld=0, first_pos is set to k and first_vld is set to 1.
  - When in_overlap=0, a match resets the valid-bit count to 0, so bits are not reused.
  - in_ready=0 and busy=1. cfg_we and in_valid are ignored.
- FLUSH: one cycle; det_z for bit WORD_W-1 is visible here; det_x=0; busy=1.
- DONE:
  - One cycle; done=1; in_ready=0; busy=0; then returns to IDLE.
- Result holding and timing:
  - match_cnt, first_pos and first_vld hold until the next accept.
  - Total: accept at E0; done high in the cycle after edge E(WORD_W+1). The next accept is possible at edge E(WORD_W+2).
- det_x and det_z are 0 outside SHIFT/FLUSH. History does not carry across words.

Decomposition:
- Package seq_scan_pkg: state enum (IDLE, SHIFT, FLUSH, DONE) and the default-pattern constant.
- Sub-module seq_match_core (clk, rst, clr, en, bit_in, pattern, overlap -> match): holds the history shift register, the saturating valid-bit count, the compare, and the registered det_z.
- The top level holds the FSM, the serialiser, the counters and the handshake.

Test Plan:
1. Reset, then in_data=16'hB000, overlap=1 -> det_z high in the cycle after bit 3; done after WORD_W+2 cycles; match_cnt=1, first_pos=3, first_vld=1.
2. in_data=16'hB600, overlap=1 -> match_cnt=2 (ends at bits 3 and 6). Same word with overlap=0 -> match_cnt=1, first_pos=3.
3. in_data=16'h0000 -> match_cnt=0, first_vld=0; done still pulses exactly once; in_ready returns to 1 on the following cycle.
4. cfg_we with cfg_pat=4'b1111 in IDLE, then in_data=16'hFFFF: overlap=1 -> match_cnt=13, first_pos=3. overlap=0 -> match_cnt=4, first_pos=3.
5. During SHIFT: cfg_we=1 with 4'b0000 and in_valid=1 -> both ignored; in_ready=0; result is unchanged from the unpatterned run; pattern is still 1011 on the next word.
6. Assert rst while bit 7 is on det_x -> all outputs go to reset values in the same cycle; no done pulse; after release, in_ready=1 and pattern=1011.
